// File: rtl/dsp_chain_fp16_sop2_inp_loader.sv
// Stream-to-wide packer for the 8-lane fp16 SOP DSP chain: assembles IN_W beats
// into an OUT_W operand vector, double-buffered (shadow fill / held output).
module dsp_chain_fp16_sop2_inp_loader #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 2048,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_flag,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int BEATS = OUT_W / IN_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  logic [BEATS-1:0][IN_W-1:0] r_shadow;
  logic [OUT_W-1:0]           r_out;
  logic [BCW-1:0]             r_beat_cnt;
  logic                       r_shadow_full;
  logic                       r_out_valid;
  logic                       r_err_flag;
  logic [CNT_W-1:0]           r_err_cnt;
  logic [CNT_W-1:0]           r_frame_cnt;

  logic w_acc, w_end, w_good, w_err, w_xfer, w_consume;

  assign in_ready  = !r_shadow_full;
  assign w_acc     = in_valid && !r_shadow_full;
  assign w_end     = (r_beat_cnt == LAST_BEAT);
  assign w_good    = w_acc && in_last && w_end;
  // Short (early last) and long (missing last) frames both drop here.
  assign w_err     = w_acc && (in_last ^ w_end);
  assign w_xfer    = r_shadow_full && (!r_out_valid || out_ready);
  assign w_consume = r_out_valid && out_ready;

  // Shadow contents are don't-care until shadow_full, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_acc) r_shadow[r_beat_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt    <= '0;
      r_shadow_full <= 1'b0;
      r_out         <= '0;
      r_out_valid   <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_acc) r_beat_cnt <= (in_last || w_end) ? '0 : r_beat_cnt + 1'b1;

      if (w_xfer)      r_shadow_full <= 1'b0;
      else if (w_good) r_shadow_full <= 1'b1;

      if (w_xfer) begin
        r_out       <= r_shadow;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_consume) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // A framing error on the same edge as err_clr wins: count restarts at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else if (w_err) begin
      r_err_flag <= 1'b1;
      r_err_cnt  <= err_clr ? CNT_W'(1) : r_err_cnt + 1'b1;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end
  end

  assign out_inp   = r_out;
  assign out_valid = r_out_valid;
  assign err_flag  = r_err_flag;
  assign err_cnt   = r_err_cnt;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_dsp_chain_fp16_sop2_inp_loader.sv
// Directed bench for the fp16 SOP input loader: frame table plus hand-written
// back-pressure, back-to-back, error-clear and mid-frame reset sequences.
module tb_dsp_chain_fp16_sop2_inp_loader;
  localparam int IN_W = 64, OUT_W = 2048, CNT_W = 16, BEATS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  in_data;
  logic             in_valid, in_last, in_ready;
  logic [OUT_W-1:0] out_inp;
  logic             out_valid, out_ready;
  logic             err_flag, err_clr;
  logic [CNT_W-1:0] err_cnt, frame_cnt;

  dsp_chain_fp16_sop2_inp_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_inp(out_inp), .out_valid(out_valid), .out_ready(out_ready),
    .err_flag(err_flag), .err_clr(err_clr), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  int exp_frames = 0;

  typedef struct {
    string       name;
    int          nbeats;
    int          last_at;   // -1: no in_last at all
    logic [15:0] base;
    bit          deliver;
    int          exp_err;   // absolute err_cnt after the frame
  } vec_t;
  vec_t tbl[5];

  function automatic logic [OUT_W-1:0] mk_vec(input logic [15:0] base);
    logic [OUT_W-1:0] r;
    logic [15:0] e;
    r = '0;
    for (int k = 0; k < BEATS; k++) begin
      e = base + 16'(k);
      r[k*IN_W +: IN_W] = {4{e}};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      for (int k = 0; k < BEATS; k++)
        if (act[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) begin
          $display("FAIL %s: beat %0d got %h expected %h", nm, k, act[k*IN_W +: IN_W], exp[k*IN_W +: IN_W]);
          break;
        end
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled there too.
  task automatic beat(input logic [15:0] v, input bit last, input bit clr);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      nchk++; nfail++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 200 cycles");
      return;
    end
    in_valid = 1'b1; in_data = {4{v}}; in_last = last; err_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base, input int nbeats, input int last_at);
    for (int k = 0; k < nbeats; k++) beat(base + 16'(k), (k == last_at), 1'b0);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic deliver_check(input string nm, input logic [15:0] base);
    int t;
    t = 0;
    while (!out_valid && t < 5) begin @(posedge clk); #1; t++; end
    chk({nm, "_valid"}, out_valid, 1);
    chk_vec({nm, "_vec"}, out_inp, mk_vec(base));
    pulse_ready();
    exp_frames++;
    chk({nm, "_frame_cnt"}, frame_cnt, exp_frames);
    chk({nm, "_valid_drop"}, out_valid, 0);
  endtask

  // Back-to-back monitor, sampled on the falling edge.
  bit mon_en = 1'b0;
  int mon_lo = 0, mon_dcnt = 0, mon_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!in_ready) mon_lo++;
      if (out_valid && out_ready) begin
        if (out_inp !== mk_vec(16'h9000 + 16'(mon_dcnt * 256))) mon_bad++;
        mon_dcnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{"short9",  10, 9,  16'h1000, 1'b0, 1};
    tbl[1] = '{"good_a",  32, 31, 16'h2000, 1'b1, 1};
    tbl[2] = '{"long",    32, -1, 16'h3000, 1'b0, 2};
    tbl[3] = '{"short0",  1,  0,  16'h4000, 1'b0, 3};
    tbl[4] = '{"good_b",  32, 31, 16'h5000, 1'b1, 3};

    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inp_lo", out_inp[63:0], 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single frame: latency and lane placement.
    send_frame(16'h3C00, 32, 31);
    chk("single_valid_n", out_valid, 0);
    chk("single_ready_gap", in_ready, 0);
    @(posedge clk); #1;
    chk("single_valid_n1", out_valid, 1);
    chk("single_ready_back", in_ready, 1);
    chk("single_lo", out_inp[63:0], 64'h3C00_3C00_3C00_3C00);
    chk("single_hi", out_inp[2047:1984], 64'h3C1F_3C1F_3C1F_3C1F);
    repeat (3) @(posedge clk); #1;
    chk("single_frame_cnt_hold", frame_cnt, 0);
    chk("single_valid_hold", out_valid, 1);
    pulse_ready();
    exp_frames++;
    chk("single_frame_cnt", frame_cnt, exp_frames);

    // Table of framing cases.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].base, tbl[i].nbeats, tbl[i].last_at);
      if (tbl[i].deliver) deliver_check(tbl[i].name, tbl[i].base);
      else begin
        repeat (3) @(posedge clk); #1;
        chk({tbl[i].name, "_no_valid"}, out_valid, 0);
      end
      chk({tbl[i].name, "_err_cnt"}, err_cnt, tbl[i].exp_err);
      chk({tbl[i].name, "_err_flag"}, err_flag, 1);
    end

    // err_clr coinciding with a short-frame error: the error wins.
    send_frame(16'h6000, 4, -1);
    beat(16'h6004, 1'b1, 1'b1);
    chk("clr_err_wins_flag", err_flag, 1);
    chk("clr_err_wins_cnt", err_cnt, 1);
    beat(16'h6100, 1'b0, 1'b1);
    chk("clr_flag", err_flag, 0);
    chk("clr_cnt", err_cnt, 0);
    for (int k = 1; k < BEATS; k++) beat(16'h6100 + 16'(k), (k == 31), 1'b0);
    deliver_check("clr_frame", 16'h6100);

    // Back-pressure: both buffers full, then combined consume+transfer.
    send_frame(16'h7000, 32, 31);
    send_frame(16'h7100, 32, 31);
    chk("bp_ready_low", in_ready, 0);
    repeat (2) @(posedge clk); #1;
    chk("bp_ready_still_low", in_ready, 0);
    chk_vec("bp_hold_a", out_inp, mk_vec(16'h7000));
    pulse_ready();
    exp_frames++;
    chk("bp_frame_cnt1", frame_cnt, exp_frames);
    chk("bp_valid_no_gap", out_valid, 1);
    chk_vec("bp_vec_b", out_inp, mk_vec(16'h7100));
    chk("bp_ready_back", in_ready, 1);
    send_frame(16'h7200, 32, 31);
    chk("bp_ready_low2", in_ready, 0);
    chk_vec("bp_hold_b", out_inp, mk_vec(16'h7100));
    pulse_ready();
    exp_frames++;
    chk_vec("bp_vec_c", out_inp, mk_vec(16'h7200));
    pulse_ready();
    exp_frames++;
    chk("bp_frame_cnt3", frame_cnt, exp_frames);
    chk("bp_valid_drop", out_valid, 0);

    // Four frames back-to-back with the array always ready.
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(16'h9000 + 16'(f * 256), 32, 31);
    repeat (3) @(posedge clk); #1;
    mon_en = 1'b0;
    out_ready = 1'b0;
    exp_frames += 4;
    chk("b2b_frame_cnt", frame_cnt, exp_frames);
    chk("b2b_delivered", mon_dcnt, 4);
    chk("b2b_vec_bad", mon_bad, 0);
    chk("b2b_ready_low_cycles", mon_lo, 4);

    // Reset in the middle of a frame.
    send_frame(16'hA000, 16, -1);
    #2 reset = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_frames = 0;
    send_frame(16'hB000, 32, 31);
    deliver_check("mrst_frame", 16'hB000);
    chk("mrst_no_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
